// File: rtl/fp_mul_result_fifo.sv
// fp_mul_result_fifo
// Small result queue that sits behind a single-precision multiplier. Each
// entry holds the 32-bit product plus its exception/overflow/underflow flags
// and is returned unchanged in strict FIFO order. The block also keeps sticky
// copies of the flags of every accepted entry (clearable) and a free-running
// count of accepted entries.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           producer handshake (in_ready from state only)
//   in_res, in_exception,
//   in_overflow, in_underflow     entry payload
//   out_valid / out_ready         consumer handshake (out_valid from state only)
//   out_res, out_exception,
//   out_overflow, out_underflow   head entry payload, all zero when empty
//   level                         number of stored entries, 0..DEPTH
//   clr_sticky                    clears the sticky flags (a same-cycle push wins)
//   sticky_exception/overflow/
//   underflow                     OR of flags accepted since last clear/reset
//   accepted_count                entries accepted since reset, wraps at 16 bits
module fp_mul_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_res,
  input  logic        in_exception,
  input  logic        in_overflow,
  input  logic        in_underflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic        out_exception,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic [2:0]  level,
  input  logic        clr_sticky,
  output logic        sticky_exception,
  output logic        sticky_overflow,
  output logic        sticky_underflow,
  output logic [15:0] accepted_count
);

  localparam int         AW         = $clog2(DEPTH);
  localparam logic [2:0] FULL_LEVEL = 3'(DEPTH);

  // Entry layout: {res[31:0], exception, overflow, underflow}
  logic [34:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [34:0]   head;

  // Handshakes depend only on the stored level, so a full queue refuses a
  // push even when the consumer pops in the same cycle.
  assign in_ready  = (level != FULL_LEVEL);
  assign out_valid = (level != 3'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage is never reset; stale contents are hidden by the empty mask.
  assign head          = mem[rd_ptr];
  assign out_res       = out_valid ? head[34:3] : 32'h0;
  assign out_exception = out_valid & head[2];
  assign out_overflow  = out_valid & head[1];
  assign out_underflow = out_valid & head[0];

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= {in_res, in_exception, in_overflow, in_underflow};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + 3'd1;
        2'b01:   level <= level - 3'd1;
        default: level <= level;
      endcase
    end
  end

  // A clear drops the old sticky state, but a flag pushed in the same cycle
  // is still recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_exception <= 1'b0;
      sticky_overflow  <= 1'b0;
      sticky_underflow <= 1'b0;
    end else if (clr_sticky) begin
      sticky_exception <= push & in_exception;
      sticky_overflow  <= push & in_overflow;
      sticky_underflow <= push & in_underflow;
    end else begin
      sticky_exception <= sticky_exception | (push & in_exception);
      sticky_overflow  <= sticky_overflow  | (push & in_overflow);
      sticky_underflow <= sticky_underflow | (push & in_underflow);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accepted_count <= 16'h0000;
    end else if (push) begin
      accepted_count <= accepted_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_fp_mul_result_fifo.sv
// Testbench for fp_mul_result_fifo: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_fp_mul_result_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_res;
  logic        in_exception, in_overflow, in_underflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_exception, out_overflow, out_underflow;
  logic [2:0]  level;
  logic        clr_sticky;
  logic        sticky_exception, sticky_overflow, sticky_underflow;
  logic [15:0] accepted_count;

  int n_compared = 0;
  int n_mismatch = 0;

  // Reference model: queue of {res, exc, ovf, unf}, sticky bits, count
  logic [34:0] model_q[$];
  logic [2:0]  model_sticky;
  logic [15:0] model_count;

  fp_mul_result_fifo #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res),
    .in_exception(in_exception), .in_overflow(in_overflow), .in_underflow(in_underflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_exception(out_exception), .out_overflow(out_overflow), .out_underflow(out_underflow),
    .level(level), .clr_sticky(clr_sticky),
    .sticky_exception(sticky_exception), .sticky_overflow(sticky_overflow),
    .sticky_underflow(sticky_underflow), .accepted_count(accepted_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output against the model's current state.
  task automatic checkAll();
    logic [34:0] h;
    int n;
    n = model_q.size();
    h = (n != 0) ? model_q[0] : 35'h0;
    checkOutput("level",     32'(level),     32'(n));
    checkOutput("in_ready",  32'(in_ready),  32'(n != 4));
    checkOutput("out_valid", 32'(out_valid), 32'(n != 0));
    checkOutput("out_res",   out_res,        h[34:3]);
    checkOutput("out_flags", 32'({out_exception, out_overflow, out_underflow}), 32'(h[2:0]));
    checkOutput("sticky",    32'({sticky_exception, sticky_overflow, sticky_underflow}), 32'(model_sticky));
    checkOutput("count",     32'(accepted_count), 32'(model_count));
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, let
  // the rising edge happen, then advance the model.
  task automatic applyStimulus(input logic v, input logic [31:0] r, input logic [2:0] f,
                               input logic ordy, input logic clr, input logic rs);
    logic do_push, do_pop;
    in_valid     = v;
    in_res       = r;
    in_exception = f[2];
    in_overflow  = f[1];
    in_underflow = f[0];
    out_ready    = ordy;
    clr_sticky   = clr;
    rst          = rs;
    #1;
    checkAll();
    do_push = v && (model_q.size() != 4);
    do_pop  = ordy && (model_q.size() != 0);
    @(posedge clk);
    if (rs) begin
      model_q.delete();
      model_sticky = 3'b000;
      model_count  = 16'h0000;
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back({r, f});
      model_sticky = (clr ? 3'b000 : model_sticky) | (do_push ? f : 3'b000);
      model_count  = model_count + (do_push ? 16'd1 : 16'd0);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 32'h0, 3'b000, ordy, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
  endtask

  logic [31:0] fill_vals [4];

  initial begin
    fill_vals[0] = 32'hC235_5062;
    fill_vals[1] = 32'h441E_5375;
    fill_vals[2] = 32'h4B80_0000;
    fill_vals[3] = 32'h361F_FFE7;
    model_sticky = 3'b000;
    model_count  = 16'h0000;

    // Bring the DUT out of its unknown power-up state before any checking.
    rst = 1'b1; in_valid = 1'b0; in_res = 32'h0;
    in_exception = 1'b0; in_overflow = 1'b0; in_underflow = 1'b0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    doReset();
    idle(1'b0);

    // Single entry
    applyStimulus(1'b1, 32'h4532_10E9, 3'b000, 1'b1, 1'b0, 1'b0);
    checkOutput("single_valid", 32'(out_valid), 32'd1);
    checkOutput("single_res",   out_res,        32'h4532_10E9);
    idle(1'b1);
    checkOutput("single_level", 32'(level),          32'd0);
    checkOutput("single_count", 32'(accepted_count), 32'd1);

    // Fill and order, fifth value refused
    doReset();
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, fill_vals[i], 3'b000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h7F80_0000, 3'b000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h7F80_0000, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("full_level", 32'(level),          32'd4);
    checkOutput("full_ready", 32'(in_ready),       32'd0);
    checkOutput("full_count", 32'(accepted_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_order", out_res, fill_vals[i]);
      // in_valid stays high: the first pop from full must not admit a push
      applyStimulus(i == 0, 32'h7F80_0000, 3'b000, 1'b1, 1'b0, 1'b0);
      if (i == 0) checkOutput("no_push_on_full_pop", 32'(accepted_count), 32'd4);
    end
    idle(1'b1);
    idle(1'b1);

    // Simultaneous push/pop at level 2 across pointer wrap
    applyStimulus(1'b1, 32'h1111_0001, 3'b000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1111_0002, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int i = 3; i < 9; i++) begin
      applyStimulus(1'b1, 32'h1111_0000 + 32'(i), 3'b000, 1'b1, 1'b0, 1'b0);
      checkOutput("pp_level", 32'(level),  32'd2);
      checkOutput("pp_head",  out_res,     32'h1111_0000 + 32'(i - 1));
    end
    idle(1'b1);
    idle(1'b1);

    // Sticky flags
    applyStimulus(1'b1, 32'h7F80_0000, 3'b110, 1'b1, 1'b0, 1'b0);
    checkOutput("sticky_set", 32'({sticky_exception, sticky_overflow, sticky_underflow}), 32'b110);
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b1, 1'b0);
    checkOutput("sticky_clr", 32'({sticky_exception, sticky_overflow, sticky_underflow}), 32'b000);
    applyStimulus(1'b1, 32'h0080_0000, 3'b001, 1'b1, 1'b1, 1'b0);
    checkOutput("sticky_setwins", 32'({sticky_exception, sticky_overflow, sticky_underflow}), 32'b001);
    idle(1'b1);

    // Reset mid-operation
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'hABCD_0000 + 32'(i), 3'b111, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h5555_5555, 3'b111, 1'b1, 1'b1, 1'b1);
    checkOutput("rst_level",  32'(level),     32'd0);
    checkOutput("rst_valid",  32'(out_valid), 32'd0);
    checkOutput("rst_res",    out_res,        32'h0);
    checkOutput("rst_sticky", 32'({sticky_exception, sticky_overflow, sticky_underflow}), 32'b000);
    checkOutput("rst_count",  32'(accepted_count), 32'd0);
    idle(1'b0);
    applyStimulus(1'b1, 32'h0000_0000, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
    checkOutput("post_rst_res",   out_res,        32'h0);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) < 60, $urandom, 3'($urandom),
                    $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 10,
                    $urandom_range(0, 99) < 2);
    end
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
